// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and mid-bit sampling
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] div_q, div_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    logic rx_s;
    logic tick;
    logic fall;

    assign rx_s = sync2_q;
    assign tick = (div_q == DIV_LAST);

    // The sync chain resets high; only once real line data has reached rx_s
    // and been seen high does a falling edge count as a start edge.
    assign fill_d  = {fill_q[0], 1'b1};
    assign armed_d = armed_q | (fill_q[1] & rx_s);
    assign fall    = armed_q & prev_q & ~rx_s;

    assign div_d = tick ? '0 : div_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_cnt_d = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        shift_d    = {rx_s, shift_q[7:1]};
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        tick_cnt_d = 4'd0;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            fill_q     <= 2'b00;
            armed_q    <= 1'b0;
            div_q      <= '0;
            state_q    <= S_IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            div_q      <= div_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != S_IDLE);

endmodule
